// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out shifter.
package piso_pkg;

    localparam int unsigned WidthDefault = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } piso_state_e;

endpackage

// File: rtl/bit_counter.sv
// Saturating bit counter with synchronous clear and a terminal-count flag at Width-1.
module bit_counter #(
    parameter int unsigned Width = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] Last = CntW'(Width - 1);

    logic [CntW-1:0] count_d;
    logic [CntW-1:0] count_q;

    assign tc_o = (count_q == Last);

    // Clear has priority; increment never wraps past the terminal count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !tc_o) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_shift_register.sv
// Accepts a parallel word with a valid/ready handshake and emits it MSB first under enable.
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    piso_state_e      state_d, state_q;
    logic [WIDTH-1:0] shift_d, shift_q;
    logic             done_d, done_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;

    bit_counter #(
        .Width (WIDTH)
    ) u_bit_counter (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Load wins over enable; enable has no meaning while idle.
                if (load_valid) begin
                    shift_d = load_data;
                    cnt_clr = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (enable) begin
                    if (cnt_tc) begin
                        shift_d = '0;
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode registered state only.
    assign load_ready   = (state_q == StIdle);
    assign serial_valid = (state_q == StShift);
    assign serial_out   = serial_valid & shift_q[WIDTH-1];
    assign done         = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed self-checking bench for piso_shift_register with hand-computed serial sequences.
module tb_piso_shift_register;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = 8'h00;
    logic       enable = 1'b0;
    logic       serial_out;
    logic       serial_valid;
    logic       done;

    int n_checks = 0;
    int n_pass = 0;

    piso_shift_register #(
        .WIDTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .enable       (enable),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check_eq({tag, " ready"}, 32'(load_ready), 32'd1);
        check_eq({tag, " valid"}, 32'(serial_valid), 32'd0);
        check_eq({tag, " sout"}, 32'(serial_out), 32'd0);
        check_eq({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    // Expects the DUT in SHIFT presenting bit 7; consumes all bits with enable=1.
    task automatic run_word(input string tag, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            check_eq($sformatf("%s bit%0d", tag, i), 32'(serial_out), 32'(w[i]));
            check_eq($sformatf("%s valid%0d", tag, i), 32'(serial_valid), 32'd1);
            check_eq($sformatf("%s nodone%0d", tag, i), 32'(done), 32'd0);
            enable = 1'b1;
            tick();
        end
        check_idle({tag, " end"}, 1'b1);
    endtask

    task automatic accept(input logic [7:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
        check_eq("accept ready low", 32'(load_ready), 32'd0);
    endtask

    logic [7:0] w80;

    initial begin
        // Reset state
        tick();
        check_idle("reset", 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_idle("post reset", 1'b0);

        // Enable alone in idle must not load or pulse done
        enable = 1'b1;
        repeat (3) tick();
        check_idle("idle enable", 1'b0);

        // A5 with enable held high
        accept(8'hA5);
        run_word("a5", 8'hA5);
        enable = 1'b0;
        tick();
        check_idle("a5 after", 1'b0);

        // 80 with enable gaps: bit held while enable low
        w80 = 8'h80;
        accept(w80);
        for (int i = 7; i >= 0; i--) begin
            enable = 1'b0;
            repeat (2) begin
                tick();
                check_eq($sformatf("80 hold%0d", i), 32'(serial_out), 32'(w80[i]));
                check_eq($sformatf("80 nodone%0d", i), 32'(done), 32'd0);
            end
            enable = 1'b1;
            tick();
        end
        check_idle("80 end", 1'b1);
        enable = 1'b0;
        tick();

        // FF with load_valid/00 offered throughout the word
        accept(8'hFF);
        load_valid = 1'b1;
        load_data  = 8'h00;
        run_word("ff", 8'hFF);
        tick();  // 00 taken on the done cycle
        load_valid = 1'b0;
        check_eq("00 accepted valid", 32'(serial_valid), 32'd1);
        run_word("00", 8'h00);

        // 3C interrupted by reset after 3 bits
        accept(8'h3C);
        enable = 1'b1;
        repeat (3) tick();
        check_eq("3c bit4", 32'(serial_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle("async reset", 1'b0);
        tick();
        reset = 1'b0;
        enable = 1'b0;
        tick();
        check_idle("reset release", 1'b0);
        tick();
        check_idle("no done after reset", 1'b0);
        accept(8'hC3);
        run_word("c3", 8'hC3);

        // Load and enable together in idle: enable ignored that cycle
        enable     = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h01;
        tick();
        load_valid = 1'b0;
        enable     = 1'b0;
        check_eq("01 first", 32'(serial_out), 32'd0);
        repeat (3) tick();
        check_eq("01 held valid", 32'(serial_valid), 32'd1);
        run_word("01", 8'h01);

        // Back-to-back 55 then AA with one done cycle between
        accept(8'h55);
        run_word("55", 8'h55);
        load_valid = 1'b1;
        load_data  = 8'hAA;
        tick();
        load_valid = 1'b0;
        check_eq("aa done cleared", 32'(done), 32'd0);
        run_word("aa", 8'hAA);
        enable = 1'b0;
        tick();
        check_idle("final", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per word (legal range 2..32).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: load_valid  input  1  producer offers load_data this cycle.
REQ-005 Port: load_ready  output  1  block can accept a word this cycle.
REQ-006 Port: load_data  input  WIDTH  parallel word to serialize.
REQ-007 Port: enable  input  1  consumer takes the current serial bit this cycle.
REQ-008 Port: serial_out  output  1  current bit, MSB first.
REQ-009 Port: serial_valid  output  1  serial_out holds a valid bit.
REQ-010 Port: done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-011 The block SHALL implement two states, IDLE and SHIFT.
REQ-012 IDLE: load_ready=1, serial_valid=0, serial_out=0.
REQ-013 IDLE with load_valid=1 at a rising edge: capture load_data into shift_reg, clear bit_count to 0, enter SHIFT.
REQ-014 SHIFT: load_ready=0, serial_valid=1, serial_out=shift_reg[WIDTH-1]; first bit visible the cycle after acceptance (latency 1).
REQ-015 SHIFT with enable=0: shift_reg, bit_count and serial_out hold; bit is held indefinitely.
REQ-016 SHIFT with enable=1 and bit_count<WIDTH-1: shift_reg shifts left one place, LSB filled with 0; bit_count increments.
REQ-017 SHIFT with enable=1 and bit_count=WIDTH-1: return to IDLE, done=1 for exactly the next cycle.
REQ-018 A word occupies WIDTH+1 cycles minimum (1 accept cycle + WIDTH consume cycles); a new load is accepted the cycle done is high.
REQ-019 load_valid during SHIFT SHALL be ignored; load_data SHALL NOT disturb shift_reg.
REQ-020 enable during IDLE SHALL be ignored; done SHALL NOT assert.
REQ-021 load_valid and enable high together in IDLE: load wins; enable ignored in that cycle.
REQ-022 bit_count width SHALL be $clog2(WIDTH); no wrap beyond WIDTH-1.
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, shift_reg=0, bit_count=0, done=0, serial_out=0, serial_valid=0, load_ready=1.
REQ-025 Reset mid-word SHALL discard the word; no done pulse; first cycle after release is IDLE.
REQ-026 Deassertion SHALL NOT itself trigger a load; load requires load_valid sampled at a later edge.

Structure
REQ-027 Package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the WIDTH default constant.
REQ-028 A single sub-module bit_counter (synchronous clear, increment enable, terminal-count flag at WIDTH-1, async reset) SHALL be instantiated.
REQ-029 Total RTL SHALL be 120-400 lines.

Verification
REQ-030 Reset, then load 8'hA5 with enable held 1 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, done high on the 9th, load_ready high again.
REQ-031 Load 8'h80, toggle enable 1,0,0,1... -> bit held while enable=0, sequence 1 then seven 0s, done only after 8th enable.
REQ-032 Load 8'hFF, drive load_valid=1 with 8'h00 throughout SHIFT -> output stays eight 1s; 8'h00 accepted only on the done cycle.
REQ-033 Load 8'h3C, assert reset after 3 bits -> outputs at reset values immediately, no done, next load 8'hC3 emits 1,1,0,0,0,0,1,1.
REQ-034 In IDLE drive enable=1 with load_valid=1, data 8'h01 -> word accepted, enable ignored, first serial_out=0 held until next enable.
REQ-035 Back-to-back loads 8'h55, 8'hAA with enable=1 -> 16 bits 0101010110101010, exactly one idle (done) cycle between words.
